pt_frame_buffer: RTL and testbench
==================================

# pt_frame_buffer

Store-and-forward Avalon-ST frame buffer for the Ethernet passthrough path. It sits between the receive FIFO source of one TSE MAC and the transmit FIFO sink of the other MAC. It forwards only complete, error-free frames, so the transmit MAC never sees a truncated or corrupted frame. Frames with RX errors, frames missing an end-of-packet, and frames that overflow the buffer are dropped and counted.

## Interface

Parameters:
- DATA_W, 32, stream data width (one beat = 4 bytes)
- EMPTY_W, 2, width of the empty field
- DEPTH_LOG2, 9, log2 of buffer depth in beats (default 512 beats = 2048 B)

Ports:
- clk  in  1  system clock; all logic is on this one clock
- reset  in  1  synchronous, active-high reset
- in_data  in  DATA_W  ingress beat data
- in_valid  in  1  ingress beat valid
- in_ready  out  1  ingress ready
- in_sop  in  1  ingress start of packet
- in_eop  in  1  ingress end of packet
- in_empty  in  EMPTY_W  unused bytes in the eop beat
- in_error  in  6  MAC RX error vector; sampled only on the eop beat
- out_data  out  DATA_W  egress beat data
- out_valid  out  1  egress beat valid
- out_ready  in  1  egress ready
- out_sop  out  1  egress start of packet
- out_eop  out  1  egress end of packet
- out_empty  out  EMPTY_W  egress empty
- out_error  out  1  egress error; constant 0
- frame_count  out  32  frames committed; wraps modulo 2^32
- drop_count  out  32  frames dropped; wraps modulo 2^32

## Operation

- Storage
  - RAM of 2^DEPTH_LOG2 words.
  - Each word holds {data, sop, eop, empty}.
  - Pointers are DEPTH_LOG2+1 bits wide: wr_ptr (write), cm_ptr (last committed), rd_ptr (read).
  - full when wr_ptr − rd_ptr == 2^DEPTH_LOG2.
- in_ready is 0 while reset is high and 1 otherwise. The block never backpressures the ingress side; it drops instead.
- Write FSM states: IDLE, WRITE, DROP. A beat counts as accepted when in_valid and in_ready are both high.
  - IDLE, beat without sop: discard; not counted.
  - IDLE, sop beat: store the beat and go to WRITE. If the beat also has eop, apply the eop rule in the same cycle.
  - WRITE, non-sop beat: store it.
  - WRITE, eop beat, in_error == 0, not full: store it, set cm_ptr to the new wr_ptr, increment frame_count, go to IDLE.
  - WRITE, eop beat, in_error != 0: set wr_ptr back to cm_ptr, increment drop_count, go to IDLE.
  - WRITE, sop beat (previous frame has no eop): set wr_ptr back to cm_ptr, increment drop_count, then store this beat as the start of a new frame; stay in WRITE.
  - Any accepted beat while full, in WRITE or IDLE-with-sop: set wr_ptr back to cm_ptr, increment drop_count. Go to DROP, or to IDLE if the beat has eop.
  - DROP: discard beats until eop, then go to IDLE. A sop seen in DROP behaves as a sop seen in IDLE.
- A frame larger than the buffer always reaches the full condition and is dropped.
- Read side
  - Data is available when rd_ptr != cm_ptr.
  - The RAM has 1-cycle read latency. A one-entry output register provides show-ahead valid.
  - out_* holds stable while out_valid is high and out_ready is low.
- Reads and writes may happen in the same cycle. full is evaluated against the registered rd_ptr.

## Timing

- Reset values: out_valid=0, out_sop=0, out_eop=0, out_data=0, out_empty=0, out_error=0, in_ready=0, frame_count=0, drop_count=0, all pointers 0, FSM in IDLE.
- Reset asserted mid-frame discards the partial frame and all buffered frames. Counters clear.
- Commit latency: if an eop beat is accepted at edge E, its frame's sop beat has out_valid=1 from edge E+2, provided the output register was empty.
- Throughput: 1 beat per cycle in and 1 beat per cycle out, sustained, including back-to-back frames with no idle gap.
- Counters update at the edge where the commit or drop decision is made.

## Test plan

- Single 16-beat frame, empty=0, out_ready=1: out_valid rises 2 cycles after the eop edge; 16 identical beats out; frame_count=1, drop_count=0.
- 8-beat frame with in_error=6'h02 on eop, then a good 4-beat frame: only the 4-beat frame is output; drop_count=1, frame_count=1.
- Three back-to-back frames (5, 1, and 12 beats; the 1-beat frame has sop=eop and empty=3) with out_ready toggling randomly at 50%: the output beat sequence matches the input exactly; out_* stays stable during stalls.
- DEPTH_LOG2=4, 20-beat frame followed by a 6-beat frame: the first frame is dropped (drop_count=1) and nothing appears at the output; the 6-beat frame passes intact.
- 3 beats starting with sop and no eop, then a new 4-beat frame: only the 4-beat frame is output; drop_count=1.
- Reset pulsed for 1 cycle during beat 5 of a 10-beat frame: out_valid=0 and counters=0 after reset; the next full frame is forwarded correctly.

Source files
------------

// File: rtl/pt_frame_buffer.sv
// pt_frame_buffer
//
// Store-and-forward Avalon-ST frame buffer for the Ethernet passthrough path.
// Ingress beats are written into a circular RAM behind an uncommitted write
// pointer. A frame becomes visible to the read side only when its eop beat
// arrives without error, at which point the commit pointer jumps forward.
// Errored, truncated (no eop) and oversized frames are rewound and counted.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   in_*                Avalon-ST sink (never backpressures; drops instead)
//   out_*               Avalon-ST source with show-ahead valid
//   frame_count         frames committed (wraps)
//   drop_count          frames dropped (wraps)

module pt_frame_buffer #(
    parameter int DATA_W     = 32,
    parameter int EMPTY_W    = 2,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic [EMPTY_W-1:0] in_empty,
    input  logic [5:0]         in_error,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sop,
    output logic               out_eop,
    output logic [EMPTY_W-1:0] out_empty,
    output logic               out_error,
    output logic [31:0]        frame_count,
    output logic [31:0]        drop_count
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int WORD_W = DATA_W + 2 + EMPTY_W;

    typedef logic [DEPTH_LOG2:0] ptr_t;
    typedef enum logic [1:0] {IDLE, WRITE, DROP} wr_state_t;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] ram_q;
    logic              ram_valid;

    ptr_t      wr_ptr, cm_ptr, rd_ptr;
    wr_state_t state;

    logic accept, full, store_cand, abandon, wr_en;
    logic data_avail, out_take, ram_take, rd_en;
    ptr_t base_ptr, next_ptr;

    // ---------------------------------------------------------------- write
    assign in_ready = ~reset;
    assign accept   = in_valid & in_ready;
    // Occupancy includes the frame currently being written, so an oversized
    // frame always runs into this condition before it can overwrite unread data.
    assign full     = (wr_ptr - rd_ptr) == ptr_t'(DEPTH);

    // Beats that would be stored: anything inside a frame, or any sop.
    assign store_cand = accept && (state == WRITE || in_sop);
    // A sop inside a frame abandons the unterminated frame before it.
    assign abandon    = (state == WRITE) && in_sop;
    // A sop always starts writing at the commit point, discarding any partial frame.
    assign base_ptr   = in_sop ? cm_ptr : wr_ptr;
    assign next_ptr   = base_ptr + 1'b1;
    assign wr_en      = store_cand && !full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            cm_ptr      <= '0;
            frame_count <= '0;
            drop_count  <= '0;
        end else if (store_cand) begin
            if (full) begin
                wr_ptr     <= cm_ptr;
                drop_count <= drop_count + 32'd1;
                state      <= in_eop ? IDLE : DROP;
            end else if (in_eop) begin
                state <= IDLE;
                if (in_error != '0) begin
                    wr_ptr     <= cm_ptr;
                    drop_count <= drop_count + 32'(abandon) + 32'd1;
                end else begin
                    wr_ptr      <= next_ptr;
                    cm_ptr      <= next_ptr;
                    frame_count <= frame_count + 32'd1;
                    drop_count  <= drop_count + 32'(abandon);
                end
            end else begin
                wr_ptr     <= next_ptr;
                drop_count <= drop_count + 32'(abandon);
                state      <= WRITE;
            end
        end else if (accept && state == DROP && in_eop) begin
            state <= IDLE;
        end
    end

    // ---------------------------------------------------------------- RAM
    // NOTE: the storage array has no reset; pointers define which words are
    // meaningful, and a reset term would stop it mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[base_ptr[DEPTH_LOG2-1:0]] <= {in_data, in_sop, in_eop, in_empty};
        if (rd_en)
            ram_q <= mem[rd_ptr[DEPTH_LOG2-1:0]];
    end

    // ---------------------------------------------------------------- read
    // Two-stage pipe: RAM output word (ram_q/ram_valid) feeding the output
    // register. Each stage advances when the stage after it can take data,
    // which keeps one beat per cycle and holds everything during a stall.
    assign data_avail = rd_ptr != cm_ptr;
    assign out_take   = !out_valid || out_ready;
    assign ram_take   = !ram_valid || out_take;
    assign rd_en      = data_avail && ram_take;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            ram_valid <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_empty <= '0;
        end else begin
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            if (ram_take)
                ram_valid <= rd_en;
            if (out_take) begin
                out_valid <= ram_valid;
                if (ram_valid)
                    {out_data, out_sop, out_eop, out_empty} <= ram_q;
            end
        end
    end

    assign out_error = 1'b0;

endmodule

// File: tb/tb_pt_frame_buffer.sv
// tb_pt_frame_buffer
//
// Directed bench for pt_frame_buffer. Two instances share the ingress bus:
// dut0 uses the default depth, dut1 uses DEPTH_LOG2=4 for the overflow case;
// sel routes in_valid to one of them. Expected beats are queued as frames
// are sent; a negedge monitor pops and compares whatever each DUT emits.

module tb_pt_frame_buffer;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic [1:0]  in_empty = '0;
    logic [5:0]  in_error = '0;
    logic        out_ready = 1'b1;
    logic        sel = 1'b0;
    bit          rnd_ready = 1'b0;

    logic        in_valid_d [2];
    logic        in_ready   [2];
    logic [31:0] out_data   [2];
    logic        out_valid  [2];
    logic        out_sop    [2];
    logic        out_eop    [2];
    logic [1:0]  out_empty  [2];
    logic        out_error  [2];
    logic [31:0] frame_count[2];
    logic [31:0] drop_count [2];

    int checks = 0;
    int errors = 0;

    beat_t       exp_q [2][$];
    bit          prev_stall [2];
    logic [36:0] saved [2];

    assign in_valid_d[0] = in_valid & ~sel;
    assign in_valid_d[1] = in_valid & sel;

    pt_frame_buffer dut0 (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid_d[0]), .in_ready(in_ready[0]),
        .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty), .in_error(in_error),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_sop(out_sop[0]), .out_eop(out_eop[0]), .out_empty(out_empty[0]),
        .out_error(out_error[0]),
        .frame_count(frame_count[0]), .drop_count(drop_count[0])
    );

    pt_frame_buffer #(.DEPTH_LOG2(4)) dut1 (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid_d[1]), .in_ready(in_ready[1]),
        .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty), .in_error(in_error),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_sop(out_sop[1]), .out_eop(out_eop[1]), .out_empty(out_empty[1]),
        .out_error(out_error[1]),
        .frame_count(frame_count[1]), .drop_count(drop_count[1])
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // Egress ready: all-ones, or a fair coin per cycle when rnd_ready is set.
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon(input int k);
        beat_t       got;
        beat_t       e;
        logic [36:0] cur;
        got = {out_data[k], out_sop[k], out_eop[k], out_empty[k]};
        cur = {out_valid[k], got};
        if (prev_stall[k])
            check($sformatf("stall_stable_dut%0d", k), 64'(cur), 64'(saved[k]));
        if (out_valid[k] && out_ready) begin
            if (exp_q[k].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat_dut%0d: got %h expected none", k, got);
            end else begin
                e = exp_q[k].pop_front();
                check($sformatf("beat_dut%0d", k), 64'(got), 64'(e));
                check($sformatf("out_error_dut%0d", k), 64'(out_error[k]), 64'd0);
            end
        end
        prev_stall[k] = out_valid[k] && !out_ready;
        saved[k]      = cur;
    endtask

    initial forever begin
        @(negedge clk);
        mon(0);
        mon(1);
    end

    task automatic send_beat(input logic [31:0] d, input logic s, input logic e,
                             input logic [1:0] emp, input logic [5:0] err);
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
        in_empty = emp;
        in_error = err;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_empty = '0;
        in_error = '0;
    endtask

    // Sends n beats; the last beat carries eop/empty/err when with_eop is set.
    // Beats are queued as expected output only when the frame should survive.
    task automatic send_frame(input int n, input logic [31:0] base, input logic [1:0] emp,
                              input logic [5:0] err, input bit with_eop, input bit good);
        beat_t b;
        logic  last;
        for (int i = 0; i < n; i++) begin
            last    = (i == n - 1) && with_eop;
            b.data  = base + 32'(i);
            b.sop   = (i == 0);
            b.eop   = last;
            b.empty = last ? emp : 2'b00;
            if (good)
                exp_q[sel].push_back(b);
            send_beat(b.data, b.sop, b.eop, b.empty, last ? err : 6'h00);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("drain_done", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input int k, input int f, input int d);
        check($sformatf("frame_count_dut%0d", k), 64'(frame_count[k]), 64'(f));
        check($sformatf("drop_count_dut%0d", k), 64'(drop_count[k]), 64'(d));
    endtask

    task automatic check_idle_outputs(input int k);
        check($sformatf("rst_out_valid_dut%0d", k), 64'(out_valid[k]), 64'd0);
        check($sformatf("rst_out_fields_dut%0d", k),
              64'({out_data[k], out_sop[k], out_eop[k], out_empty[k], out_error[k]}), 64'd0);
        check_counts(k, 0, 0);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_in_ready_dut%0d", k), 64'(in_ready[k]), 64'd0);
            check_idle_outputs(k);
        end
        reset = 1'b0;
        #1;
        check("in_ready_after_reset", 64'(in_ready[0]), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: single 16-beat frame, commit latency
        sel = 1'b0;
        do_reset();
        send_frame(16, 32'h1000_0000, 2'd0, 6'h00, 1'b1, 1'b1);
        check("latency_e0", 64'(out_valid[0]), 64'd0);
        @(posedge clk);
        #1;
        check("latency_e1", 64'(out_valid[0]), 64'd0);
        @(posedge clk);
        #1;
        check("latency_e2", 64'(out_valid[0]), 64'd1);
        check("latency_e2_sop", 64'(out_sop[0]), 64'd1);
        drain();
        check_counts(0, 1, 0);

        // 2: errored 8-beat frame followed by a good 4-beat frame
        do_reset();
        send_frame(8, 32'h2000_0000, 2'd0, 6'h02, 1'b1, 1'b0);
        send_frame(4, 32'h2100_0000, 2'd2, 6'h00, 1'b1, 1'b1);
        drain();
        check_counts(0, 1, 1);

        // 3: back-to-back 5 / 1 / 12 beat frames with random egress stalls
        do_reset();
        rnd_ready = 1'b1;
        send_frame(5,  32'h3000_0000, 2'd0, 6'h00, 1'b1, 1'b1);
        send_frame(1,  32'h3100_0000, 2'd3, 6'h00, 1'b1, 1'b1);
        send_frame(12, 32'h3200_0000, 2'd1, 6'h00, 1'b1, 1'b1);
        drain();
        rnd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_counts(0, 3, 0);

        // 4: 16-beat buffer, 20-beat frame overflows, 6-beat frame passes
        do_reset();
        sel = 1'b1;
        send_frame(20, 32'h4000_0000, 2'd0, 6'h00, 1'b1, 1'b0);
        send_frame(6,  32'h4100_0000, 2'd1, 6'h00, 1'b1, 1'b1);
        drain();
        check_counts(1, 1, 1);
        check_counts(0, 0, 0);
        sel = 1'b0;

        // 5: 3 beats with no eop, then a new 4-beat frame
        do_reset();
        send_frame(3, 32'h5000_0000, 2'd0, 6'h00, 1'b0, 1'b0);
        send_frame(4, 32'h5100_0000, 2'd0, 6'h00, 1'b1, 1'b1);
        drain();
        check_counts(0, 1, 1);

        // 6: reset pulse during beat 5 of a 10-beat frame
        do_reset();
        send_frame(2, 32'h6000_0000, 2'd0, 6'h00, 1'b1, 1'b1);
        drain();
        check_counts(0, 1, 0);
        for (int i = 0; i < 4; i++)
            send_beat(32'h6100_0000 + 32'(i), i == 0, 1'b0, 2'd0, 6'h00);
        reset = 1'b1;
        send_beat(32'h6100_0004, 1'b0, 1'b0, 2'd0, 6'h00);
        reset = 1'b0;
        check_idle_outputs(0);
        // Tail of the interrupted frame has no sop and must be discarded.
        for (int i = 5; i < 10; i++)
            send_beat(32'h6100_0000 + 32'(i), 1'b0, i == 9, 2'd0, 6'h00);
        send_frame(10, 32'h6200_0000, 2'd2, 6'h00, 1'b1, 1'b1);
        drain();
        check_counts(0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
